cgra_config_loader: RTL and testbench

- Sequences bitstream loading into a CGRA PE's serial ConfigCell/const chain.
- Accepts parallel configuration words from a host over valid/ready and serializes them onto the chain's ConfigIn.
- Drives the enable for the gated Config_Clock of the chain, counts bits, and reports completion.
- Sits between the fabric-level config controller and one PE chain.

---
 rtl/cgra_config_loader.sv | 166 ++++++++++++++++
 tb/tb_cgra_config_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader.sv
// Serializes host configuration words LSB-first onto a PE ConfigCell/const chain.
// Optional CRC-16 readback check of the chain is compiled in by defining CFG_LOADER_VERIFY_EN.
module cgra_config_loader #(
    parameter int unsigned CHAIN_LEN = 46,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_data,
    output logic              cfg_shift_en,
    input  logic              cfg_return,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WordLen  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    if ((64'(1) << CNT_W) <= 64'(CHAIN_LEN)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to count CHAIN_LEN bits");
    end

`ifdef CFG_LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StFetch, StShift, StVerify, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StShift, StDone} state_e;
`endif

    state_e             state_q;
    logic  [WORD_W-1:0] shift_q;
    logic  [CNT_W-1:0]  word_cnt_q;
    logic  [CNT_W-1:0]  bit_cnt_q;

`ifdef CFG_LOADER_VERIFY_EN
    logic [15:0]      crc_sent_q;
    logic [15:0]      crc_ret_q;
    logic [CNT_W-1:0] vfy_cnt_q;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    logic unused_return;
    assign unused_return = cfg_return;
    assign error         = 1'b0;
`endif

    always_ff @(posedge Config_Clock) begin
        if (Config_Reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            word_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            word_ready   <= 1'b0;
            cfg_data     <= 1'b0;
            cfg_shift_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
            error        <= 1'b0;
            crc_sent_q   <= 16'hFFFF;
            crc_ret_q    <= 16'hFFFF;
            vfy_cnt_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StFetch;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                        bit_cnt_q  <= '0;
`ifdef CFG_LOADER_VERIFY_EN
                        error      <= 1'b0;
                        crc_sent_q <= 16'hFFFF;
`endif
                    end
                end

                StFetch: begin
                    // Bit 0 goes straight to cfg_data so the first SHIFT cycle already presents it.
                    if (word_valid) begin
                        state_q      <= StShift;
                        word_ready   <= 1'b0;
                        shift_q      <= word_data >> 1;
                        cfg_data     <= word_data[0];
                        cfg_shift_en <= 1'b1;
                        word_cnt_q   <= CntOne;
                        bit_cnt_q    <= bit_cnt_q + CntOne;
                    end
                end

                StShift: begin
`ifdef CFG_LOADER_VERIFY_EN
                    crc_sent_q <= crc_step(crc_sent_q, cfg_data);
`endif
                    if (bit_cnt_q == ChainLen) begin
`ifdef CFG_LOADER_VERIFY_EN
                        // The cfg_data flop joins the ring, so CHAIN_LEN+1 rotations restore the chain.
                        state_q   <= StVerify;
                        cfg_data  <= cfg_return;
                        vfy_cnt_q <= '0;
                        crc_ret_q <= 16'hFFFF;
`else
                        state_q      <= StDone;
                        cfg_data     <= 1'b0;
                        cfg_shift_en <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
`endif
                    end else if (word_cnt_q == WordLen) begin
                        state_q      <= StFetch;
                        word_ready   <= 1'b1;
                        cfg_data     <= 1'b0;
                        cfg_shift_en <= 1'b0;
                    end else begin
                        cfg_data   <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        word_cnt_q <= word_cnt_q + CntOne;
                        bit_cnt_q  <= bit_cnt_q + CntOne;
                    end
                end

`ifdef CFG_LOADER_VERIFY_EN
                StVerify: begin
                    if (vfy_cnt_q != ChainLen) begin
                        cfg_data  <= cfg_return;
                        crc_ret_q <= crc_step(crc_ret_q, cfg_return);
                        vfy_cnt_q <= vfy_cnt_q + CntOne;
                    end else begin
                        state_q      <= StDone;
                        error        <= (crc_sent_q != crc_ret_q);
                        cfg_data     <= 1'b0;
                        cfg_shift_en <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end
                end
`endif

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q      <= StIdle;
                    word_ready   <= 1'b0;
                    cfg_data     <= 1'b0;
                    cfg_shift_en <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Randomized scoreboard bench for cgra_config_loader against a bit-stream reference model.
// Verify-mode tests are included when CFG_LOADER_VERIFY_EN is defined.
module tb_cgra_config_loader;

    localparam int CHAIN_LEN = 46;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 16;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CFG_LOADER_VERIFY_EN
    localparam int  VFY_CYC    = CHAIN_LEN + 1;
    localparam bit  VERIFY_ON  = 1'b1;
`else
    localparam int  VFY_CYC    = 0;
    localparam bit  VERIFY_ON  = 1'b0;
`endif
    localparam logic [CHAIN_LEN-1:0] FLIP = CHAIN_LEN'(1) << 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              cfg_data;
    logic              cfg_shift_en;
    logic              cfg_return;
    logic              busy;
    logic              done;
    logic              error;

    cgra_config_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .Config_Clock (clk),
        .Config_Reset (rst),
        .start        (start),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .cfg_data     (cfg_data),
        .cfg_shift_en (cfg_shift_en),
        .cfg_return   (cfg_return),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: cell 0 takes cfg_data, the last cell drives cfg_return.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 inject = 1'b0;
    always @(posedge clk)
        if (cfg_shift_en) chain <= {chain[CHAIN_LEN-2:0], cfg_data} ^ (inject ? FLIP : '0);
    assign cfg_return = chain[CHAIN_LEN-1];

    typedef struct {
        int unsigned          cyc;
        logic                 err;
        logic                 chk_chain;
        logic [CHAIN_LEN-1:0] chain;
    } done_t;

    logic  exp_bits[$];
    done_t exp_done[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT shifts a bit or pulses done.
    initial begin : monitor
        int    sent_cnt;
        int    vfy_cnt;
        done_t d;
        sent_cnt = 0;
        vfy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sent_cnt = 0;
                vfy_cnt  = 0;
                exp_bits.delete();
                exp_done.delete();
            end else begin
                if (word_ready) check("shift_en_in_fetch", 64'(cfg_shift_en), 64'(0));
                if (cfg_shift_en) begin
                    if (sent_cnt < CHAIN_LEN) begin
                        if (exp_bits.size() == 0) fail("unexpected_shift_bit");
                        else check("cfg_data", 64'(cfg_data), 64'(exp_bits.pop_front()));
                        sent_cnt++;
                    end else begin
                        vfy_cnt++;
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_cycle", 64'(cyc), 64'(d.cyc));
                        check("busy_at_done", 64'(busy), 64'(0));
                        check("error_at_done", 64'(error), 64'(d.err));
                        check("shift_count", 64'(sent_cnt), 64'(CHAIN_LEN));
                        check("verify_shift_count", 64'(vfy_cnt), 64'(VFY_CYC));
                        if (d.chk_chain) check("chain_contents", 64'(chain), 64'(d.chain));
                    end
                    sent_cnt = 0;
                    vfy_cnt  = 0;
                end
            end
        end
    end

    // One complete load: the reference stream is the words concatenated LSB first, cut to
    // CHAIN_LEN bits; done comes one cycle after the last shift (plus the readback pass).
    task automatic do_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                           input int g0, input int g1, input logic inj);
        logic [WORD_W-1:0]    words[$];
        int                   gaps[$];
        logic [WORD_W-1:0]    wv;
        logic [CHAIN_LEN-1:0] exp_chain;
        int                   dly;
        int                   t;
        done_t                d;
        words = '{w0, w1};
        gaps  = '{g0, g1};
        exp_chain = '0;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            wv = words[k / WORD_W] >> (k % WORD_W);
            exp_bits.push_back(wv[0]);
            exp_chain = exp_chain | (CHAIN_LEN'(wv[0]) << (CHAIN_LEN - 1 - k));
        end
        dly = 1 + VFY_CYC;
        for (int i = 0; i < NWORDS; i++)
            dly += gaps[i] + 1 + ((CHAIN_LEN - i * WORD_W < WORD_W) ? CHAIN_LEN - i * WORD_W
                                                                   : WORD_W);
        @(negedge clk);
        start = 1'b1;
        d.cyc       = cyc + dly;
        d.err       = inj & VERIFY_ON;
        d.chk_chain = !inj;
        d.chain     = exp_chain;
        exp_done.push_back(d);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            t = 0;
            while (!word_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!word_ready) begin
                fail("word_ready_timeout");
                return;
            end
            repeat (gaps[i]) @(negedge clk);
            word_valid = 1'b1;
            word_data  = words[i];
            @(negedge clk);
            word_valid = 1'b0;
            word_data  = $urandom;
        end
        t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail("busy_timeout");
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_ready"}, 64'(word_ready), 64'(0));
        check({tag, "_cfg_data"}, 64'(cfg_data), 64'(0));
        check({tag, "_cfg_shift_en"}, 64'(cfg_shift_en), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation did not complete");
    end

    initial begin : stimulus
        logic [WORD_W-1:0] w;
        int                c0;
        rst        = 1'b1;
        start      = 1'b1;
        word_valid = 1'b0;
        word_data  = $urandom;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_during_reset_ignored", 64'(busy), 64'(0));

        // Basic load and backpressure.
        do_load(32'h89ABCDEF, 32'h00002F5A, 0, 0, 1'b0);
        do_load($urandom, $urandom, 5, 5, 1'b0);

        // Random words and host stalls.
        for (int i = 0; i < 6; i++)
            do_load($urandom, $urandom, int'($urandom_range(4)), int'($urandom_range(4)), 1'b0);

        // start while busy must be ignored.
        fork
            do_load($urandom, $urandom, 0, 0, 1'b0);
            begin
                repeat (11) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join

        // Reset mid-load, with start held alongside reset, then a clean full reload.
        w = $urandom;
        for (int k = 0; k < WORD_W; k++) exp_bits.push_back(w[k]);
        @(negedge clk);
        start = 1'b1;
        c0    = int'(cyc);
        @(negedge clk);
        start      = 1'b0;
        word_valid = 1'b1;
        word_data  = w;
        @(negedge clk);
        word_valid = 1'b0;
        while (int'(cyc) < c0 + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        start = 1'b1;
        @(negedge clk);
        check("reset_beats_start_busy", 64'(busy), 64'(0));
        check("reset_beats_start_ready", 64'(word_ready), 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        do_load($urandom, $urandom, 1, 2, 1'b0);

`ifdef CFG_LOADER_VERIFY_EN
        // Corrupt one chain cell during readback: error must rise with done and hold.
        fork
            do_load($urandom, $urandom, 0, 0, 1'b1);
            begin
                repeat (50) @(negedge clk);
                inject = 1'b1;
                @(negedge clk);
                inject = 1'b0;
            end
        join
        check("error_held", 64'(error), 64'(1));
        repeat (3) @(negedge clk);
        check("error_still_held", 64'(error), 64'(1));
        do_load($urandom, $urandom, 0, 0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("bits_drained", 64'(exp_bits.size()), 64'(0));
        check("dones_drained", 64'(exp_done.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
